imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed big-endian byte stream into
// instruction-memory word writes, then releases the CPU.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        startin,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        load_err
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, DONE, ERR} state_e;

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] shift_q;
  logic        we_q;
  logic        run_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        xfer;
  logic [15:0] hdr_count;
  logic [15:0] word_next;

  assign byte_ready = state_q inside {HDR0, HDR1, DATA};
  assign xfer       = byte_valid & byte_ready;
  assign hdr_count  = {count_q[15:8], byte_data};
  assign word_next  = word_idx_q + 16'd1;

  // A reset landing on the WRITE cycle must not let the strobe escape.
  assign imem_we    = we_q & startin;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = run_q;
  assign load_err   = err_q;

  always_ff @(posedge clk) begin
    if (!startin) begin
      state_q    <= HDR0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      we_q       <= 1'b0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        HDR0: if (xfer) begin
          count_q <= {byte_data, 8'h00};
          state_q <= HDR1;
        end
        HDR1: if (xfer) begin
          count_q <= hdr_count;
          if (hdr_count == 16'd0) begin
            run_q   <= 1'b1;
            state_q <= DONE;
          end else if (32'(hdr_count) > MAX_WORDS) begin
            err_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            word_idx_q <= '0;
            byte_idx_q <= '0;
            state_q    <= DATA;
          end
        end
        DATA: if (xfer) begin
          shift_q    <= {shift_q[15:0], byte_data};
          byte_idx_q <= byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wdata_q <= {shift_q, byte_data};
            addr_q  <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            we_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          word_idx_q <= word_next;
          if (word_next == count_q) begin
            run_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= DATA;
          end
        end
        DONE: state_q <= DONE;
        ERR:  state_q <= ERR;
        default: state_q <= ERR;
      endcase
    end
  end

endmodule
